// File: rtl/tbd_byte_read_bridge.sv
// Byte-read responder for accelerator initiators: fetches the containing word
// over OBI and returns the addressed byte, with a one-word hit buffer.
module tbd_byte_read_bridge #(
  parameter logic [31:0] ADDR_BASE  = 32'h1000_0000,
  parameter logic [31:0] ADDR_SIZE  = 32'h0000_1000,
  parameter bit          HIT_BUF_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc_req,
  input  logic [31:0] acc_addr,
  output logic [7:0]  acc_rdata,
  output logic        acc_rvalid,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i,
  input  logic        inv_i,
  input  logic        err_clr_i,
  output logic [2:0]  err_o,
  output logic [15:0] bus_reads_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [7:0]  rdata_q;
  logic        rvalid_q;
  logic        obi_req_q;
  logic [31:0] obi_addr_q;
  logic [2:0]  err_q;
  logic [2:0]  err_d;
  logic [15:0] bus_reads_q;
  logic        buf_valid_q;
  logic [29:0] buf_tag_q;
  logic [31:0] buf_data_q;
  logic        no_cache_q;

  logic [31:0] offset_s;
  logic        out_of_win_s;
  logic        hit_s;
  logic [2:0]  err_set_s;

  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
    sel_byte = word[{idx, 3'b000} +: 8];
  endfunction

  // Request classification and sticky-error next state (set beats clear).
  always_comb begin
    offset_s     = acc_addr - ADDR_BASE;
    out_of_win_s = (offset_s >= ADDR_SIZE);
    hit_s        = HIT_BUF_EN && buf_valid_q && (buf_tag_q == acc_addr[31:2]) && !inv_i;
    err_set_s    = {acc_req && (state_q != IDLE),
                    (state_q == WAIT_R) && obi_rvalid_i && obi_err_i,
                    acc_req && (state_q == IDLE) && out_of_win_s};
    err_d        = (err_clr_i ? 3'b000 : err_q) | err_set_s;
  end

  // Main FSM with all outputs and the hit buffer registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0000_0000;
      rdata_q     <= 8'h00;
      rvalid_q    <= 1'b0;
      obi_req_q   <= 1'b0;
      obi_addr_q  <= 32'h0000_0000;
      err_q       <= 3'b000;
      bus_reads_q <= 16'h0000;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= 30'h0000_0000;
      buf_data_q  <= 32'h0000_0000;
      no_cache_q  <= 1'b0;
    end else begin
      err_q    <= err_d;
      rvalid_q <= 1'b0;
      if (inv_i) begin
        buf_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (acc_req) begin
            addr_q <= acc_addr;
            if (out_of_win_s) begin
              rdata_q  <= 8'h00;
              rvalid_q <= 1'b1;
              state_q  <= RESP;
            end else if (hit_s) begin
              rdata_q  <= sel_byte(buf_data_q, acc_addr[1:0]);
              rvalid_q <= 1'b1;
              state_q  <= RESP;
            end else begin
              obi_req_q  <= 1'b1;
              obi_addr_q <= {acc_addr[31:2], 2'b00};
              no_cache_q <= 1'b0;
              state_q    <= REQ;
            end
          end
        end
        REQ: begin
          if (inv_i) begin
            no_cache_q <= 1'b1;
          end
          if (obi_gnt_i) begin
            obi_req_q   <= 1'b0;
            bus_reads_q <= bus_reads_q + 16'd1;
            state_q     <= WAIT_R;
          end
        end
        WAIT_R: begin
          if (inv_i) begin
            no_cache_q <= 1'b1;
          end
          if (obi_rvalid_i) begin
            rvalid_q <= 1'b1;
            state_q  <= RESP;
            if (obi_err_i) begin
              rdata_q     <= 8'h00;
              buf_valid_q <= 1'b0;
            end else begin
              rdata_q <= sel_byte(obi_rdata_i, addr_q[1:0]);
              // An invalidate seen during the transaction keeps this word out of the buffer.
              if (HIT_BUF_EN && !no_cache_q && !inv_i) begin
                buf_valid_q <= 1'b1;
                buf_tag_q   <= addr_q[31:2];
                buf_data_q  <= obi_rdata_i;
              end
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign acc_rdata   = rdata_q;
  assign acc_rvalid  = rvalid_q;
  assign obi_req_o   = obi_req_q;
  assign obi_addr_o  = obi_addr_q;
  assign obi_we_o    = 1'b0;
  assign obi_be_o    = 4'b1111;
  assign err_o       = err_q;
  assign bus_reads_o = bus_reads_q;

endmodule

// File: tb/tb_tbd_byte_read_bridge.sv
// Scoreboard bench for tbd_byte_read_bridge: stimulus pushes expected bytes and
// latencies, a monitor pops them on every acc_rvalid, an OBI responder serves memory.
module tb_tbd_byte_read_bridge;

  logic        clk;
  logic        rst_n;
  logic        acc_req;
  logic [31:0] acc_addr;
  logic [7:0]  acc_rdata;
  logic        acc_rvalid;
  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic        obi_rvalid_i;
  logic [31:0] obi_rdata_i;
  logic        obi_err_i;
  logic        inv_i;
  logic        err_clr_i;
  logic [2:0]  err_o;
  logic [15:0] bus_reads_o;

  tbd_byte_read_bridge dut (
    .clk(clk), .rst_n(rst_n), .acc_req(acc_req), .acc_addr(acc_addr),
    .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid), .obi_req_o(obi_req_o),
    .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
    .obi_be_o(obi_be_o), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
    .obi_err_i(obi_err_i), .inv_i(inv_i), .err_clr_i(err_clr_i), .err_o(err_o),
    .bus_reads_o(bus_reads_o)
  );

  typedef struct {
    logic [7:0] data;
    int         issue;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rsp_count = 0;
  int   obi_reqs = 0;
  int   gnt_wait = 0;
  int   rv_wait = 0;
  logic rsp_err = 1'b0;
  logic resp_en = 1'b1;
  int   stale_cnt = 0;
  int   stale_done = 0;
  logic [31:0] last_obi_addr = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h1000_0000: return 32'h4433_2211;
      32'h1000_0004: return 32'h8877_6655;
      default:       return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // Monitor: every response must match the oldest expectation in data and latency.
  always @(negedge clk) begin
    if (acc_rvalid === 1'b1) begin
      rsp_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rdata %h with no request pending", acc_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", {24'h0, acc_rdata}, {24'h0, e.data});
        chk("latency", cyc - e.issue, e.lat);
      end
    end
  end

  // OBI responder: grants after gnt_wait cycles, answers after rv_wait more.
  initial begin
    logic [31:0] req_addr;
    obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0; obi_err_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stale_cnt != stale_done) begin
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        obi_rvalid_i = 1'b0;
        stale_done++;
      end else if (resp_en && obi_req_o === 1'b1) begin
        req_addr = obi_addr_o;
        last_obi_addr = req_addr;
        for (int i = 0; i < gnt_wait; i++) begin
          chk("obi_req_held", {31'h0, obi_req_o}, 32'h1);
          chk("obi_addr_stable", obi_addr_o, req_addr);
          @(posedge clk); #1;
        end
        chk("obi_addr_at_gnt", obi_addr_o, req_addr);
        obi_gnt_i = 1'b1;
        obi_reqs++;
        @(posedge clk); #1;
        obi_gnt_i = 1'b0;
        for (int i = 0; i < rv_wait; i++) begin
          @(posedge clk); #1;
        end
        obi_rvalid_i = 1'b1; obi_rdata_i = mem_word(req_addr); obi_err_i = rsp_err;
        @(posedge clk); #1;
        obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
      end
    end
  end

  // Issue one read; optional inv_i / extra acc_req pulses at relative cycles.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] exp_b, input int lat,
                         input int inv_at, input int ovr_at);
    int   target;
    exp_t e;
    bit   done;
    @(posedge clk); #1;
    target = rsp_count + 1;
    e.data = exp_b; e.issue = cyc; e.lat = lat;
    sb.push_back(e);
    acc_req = 1'b1; acc_addr = addr;
    done = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      acc_req = (k == ovr_at);
      acc_addr = (k == ovr_at) ? 32'h1000_0100 : addr;
      inv_i = (k == inv_at);
      if (rsp_count >= target) begin
        done = 1'b1;
        break;
      end
    end
    acc_req = 1'b0; inv_i = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: no acc_rvalid for addr %h within 60 cycles", addr);
    end
  endtask

  task automatic pulse_inv();
    @(posedge clk); #1; inv_i = 1'b1;
    @(posedge clk); #1; inv_i = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; err_clr_i = 1'b1;
    @(posedge clk); #1; err_clr_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; acc_req = 1'b0; acc_addr = 32'h0; inv_i = 1'b0; err_clr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", {31'h0, acc_rvalid}, 32'h0);
    chk("rst_rdata", {24'h0, acc_rdata}, 32'h0);
    chk("rst_obi_req", {31'h0, obi_req_o}, 32'h0);
    chk("rst_obi_addr", obi_addr_o, 32'h0);
    chk("rst_err", {29'h0, err_o}, 32'h0);
    chk("rst_bus_reads", {16'h0, bus_reads_o}, 32'h0);
    chk("obi_we_be", {27'h0, obi_we_o, obi_be_o}, 32'h0000_000F);
    rst_n = 1'b1;

    // First miss and sequential hits
    do_read(32'h1000_0000, 8'h11, 3, 0, 0);
    chk("bus_reads_first", {16'h0, bus_reads_o}, 32'd1);
    chk("obi_addr_first", last_obi_addr, 32'h1000_0000);
    do_read(32'h1000_0001, 8'h22, 1, 0, 0);
    do_read(32'h1000_0002, 8'h33, 1, 0, 0);
    do_read(32'h1000_0003, 8'h44, 1, 0, 0);
    chk("bus_reads_hits", {16'h0, bus_reads_o}, 32'd1);
    chk("obi_reqs_hits", obi_reqs, 32'd1);

    // Invalidate between reads, and during REQ
    do_read(32'h1000_0004, 8'h55, 3, 0, 0);
    pulse_inv();
    do_read(32'h1000_0000, 8'h11, 3, 0, 0);
    chk("bus_reads_inv", {16'h0, bus_reads_o}, 32'd3);
    do_read(32'h1000_0001, 8'h22, 1, 0, 0);
    pulse_inv();
    do_read(32'h1000_0002, 8'h33, 3, 0, 0);
    do_read(32'h1000_0004, 8'h55, 3, 1, 0);
    do_read(32'h1000_0005, 8'h66, 3, 0, 0);
    do_read(32'h1000_0006, 8'h77, 1, 0, 0);
    chk("bus_reads_inv_req", {16'h0, bus_reads_o}, 32'd6);

    // Window boundaries
    do_read(32'h1000_1000, 8'h00, 1, 0, 0);
    chk("oow_no_obi", obi_reqs, 32'd6);
    chk("err_oow", {29'h0, err_o}, 32'h1);
    pulse_clr();
    chk("err_clr", {29'h0, err_o}, 32'h0);
    do_read(32'h0FFF_FFFF, 8'h00, 1, 0, 0);
    chk("err_below_base", {29'h0, err_o}, 32'h1);
    pulse_clr();
    do_read(32'h1000_0FFF, 8'hB5, 3, 0, 0);
    chk("bus_reads_last_byte", {16'h0, bus_reads_o}, 32'd7);

    // Delayed grant and response with bus error
    gnt_wait = 4; rv_wait = 1; rsp_err = 1'b1;
    do_read(32'h1000_0008, 8'h00, 8, 0, 0);
    gnt_wait = 0; rv_wait = 0; rsp_err = 1'b0;
    chk("err_bus", {29'h0, err_o}, 32'h2);
    chk("obi_addr_err", last_obi_addr, 32'h1000_0008);
    do_read(32'h1000_0FFE, 8'hA5, 3, 0, 0);
    do_read(32'h1000_0008, 8'hAD, 3, 0, 0);
    chk("bus_reads_after_err", {16'h0, bus_reads_o}, 32'd10);
    pulse_clr();

    // Overrun: second acc_req while waiting for the response
    rv_wait = 3;
    do_read(32'h1000_000C, 8'hA9, 6, 0, 2);
    rv_wait = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("err_overrun", {29'h0, err_o}, 32'h4);
    chk("bus_reads_overrun", {16'h0, bus_reads_o}, 32'd11);

    // Asynchronous reset during REQ, then a stale response
    resp_en = 1'b0;
    @(posedge clk); #1; acc_req = 1'b1; acc_addr = 32'h1000_0010;
    @(posedge clk); #1; acc_req = 1'b0;
    @(posedge clk); #1;
    chk("req_before_rst", {31'h0, obi_req_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("req_async_drop", {31'h0, obi_req_o}, 32'h0);
    chk("err_async_rst", {29'h0, err_o}, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    stale_cnt++;
    repeat (5) @(posedge clk);
    #1;
    chk("stale_bus_reads", {16'h0, bus_reads_o}, 32'h0);
    chk("stale_no_req", {31'h0, obi_req_o}, 32'h0);
    chk("stale_err", {29'h0, err_o}, 32'h0);
    resp_en = 1'b1;
    do_read(32'h1000_0000, 8'h11, 3, 0, 0);
    chk("bus_reads_after_rst", {16'h0, bus_reads_o}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
